// File: rtl/char_playback.sv
// Character playback reader: walks dmem from BASE_ADDR after EOF and hands
// each stored plot-text character to the command decoder over valid/ready.
module char_playback #(
  parameter int                 ADDR_W    = 12,
  parameter int                 CHAR_W    = 6,
  parameter logic [ADDR_W-1:0]  BASE_ADDR = ADDR_W'(1),
  parameter logic [CHAR_W-1:0]  END_CODE  = CHAR_W'('h3F)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] char_count,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_q,
  output logic [CHAR_W-1:0] char_out,
  output logic              char_valid,
  input  logic              char_ready,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] sent_count
);

  typedef enum logic [2:0] {IDLE, ADDR, CAPT, PRES, FIN} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W-1:0] count;
  logic [ADDR_W-1:0] ptr_inc;
  logic [CHAR_W-1:0] mem_char;
  logic              unused_hi;

  assign ptr_inc   = ptr + 1'b1;
  assign mem_char  = mem_q[CHAR_W-1:0];
  assign unused_hi = ^mem_q[31:CHAR_W];

  assign busy = (state != IDLE);
  assign done = (state == FIN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = (char_count == '0) ? FIN : ADDR;
      ADDR: state_nxt = CAPT;
      CAPT: state_nxt = (mem_char == END_CODE) ? FIN : PRES;
      PRES: if (char_ready) state_nxt = (ptr_inc == count) ? FIN : ADDR;
      FIN:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // mem_addr is loaded on the edge entering ADDR so dmem samples it at the
  // end of ADDR and the read data lands in CAPT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr        <= '0;
      count      <= '0;
      sent_count <= '0;
      mem_addr   <= '0;
      char_out   <= '0;
      char_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            count      <= char_count;
            ptr        <= '0;
            sent_count <= '0;
            if (char_count != '0) mem_addr <= BASE_ADDR;
          end
        end
        CAPT: begin
          if (mem_char != END_CODE) begin
            char_out   <= mem_char;
            char_valid <= 1'b1;
          end
        end
        PRES: begin
          if (char_ready) begin
            sent_count <= sent_count + 1'b1;
            ptr        <= ptr_inc;
            char_valid <= 1'b0;
            if (ptr_inc != count) mem_addr <= BASE_ADDR + ptr_inc;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_char_playback.sv
// Randomized bench for char_playback against a queue-based model of the
// expected character stream, addresses and handshake timing.
module tb_char_playback;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start0, start1;
  logic [11:0] cnt0, cnt1;
  logic [11:0] addr0, addr1;
  logic [31:0] q0, q1;
  logic [5:0]  out0, out1;
  logic        valid0, valid1;
  logic        ready0, ready1;
  logic        busy0, busy1;
  logic        done0, done1;
  logic [11:0] sent0, sent1;

  int checks   = 0;
  int failures = 0;

  logic [31:0] mem [0:4095];
  logic [5:0]  exp_c[$];
  logic [11:0] exp_a[$];
  bit          exp_term;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    q0 <= mem[addr0];
    q1 <= mem[addr1];
  end

  char_playback dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .char_count(cnt0),
    .mem_addr(addr0), .mem_q(q0), .char_out(out0), .char_valid(valid0),
    .char_ready(ready0), .busy(busy0), .done(done0), .sent_count(sent0)
  );

  char_playback #(.BASE_ADDR(12'hFFF)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .char_count(cnt1),
    .mem_addr(addr1), .mem_q(q1), .char_out(out1), .char_valid(valid1),
    .char_ready(ready1), .busy(busy1), .done(done1), .sent_count(sent1)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: characters from base up to count, stopping at the terminator.
  task automatic build_exp(input logic [11:0] base, input int n);
    logic [11:0] a;
    exp_c.delete();
    exp_a.delete();
    exp_term = 1'b0;
    for (int i = 0; i < n; i++) begin
      a = base + 12'(i);
      if (mem[a][5:0] == 6'h3F) begin
        exp_term = 1'b1;
        break;
      end
      exp_c.push_back(mem[a][5:0]);
      exp_a.push_back(a);
    end
  endtask

  task automatic put(input int a, input logic [5:0] c);
    mem[a] = {$urandom} & 32'hFFFF_FFC0 | {26'd0, c};
  endtask

  // Runs one playback on dut0; entered and left on a negedge with dut0 idle.
  // mode 0: ready always high, 1: 4-cycle stall per char, 2: random.
  task automatic run_play(input int n, input int mode, input string tag);
    int idx, t, last_hs, stall, exp_t;
    bit fin, was_valid;
    logic [5:0] held;
    build_exp(12'd1, n);
    idx = 0; t = 0; last_hs = -1; stall = 0; fin = 0; was_valid = 0; held = '0;
    start0 = 1'b1;
    cnt0   = 12'(n);
    while (!fin) begin
      @(negedge clk);
      t++;
      if (t == 1) begin
        start0 = 1'b0;
        cnt0   = 12'($urandom);
      end
      if (t > 400) begin
        checks++; failures++;
        $display("FAIL %s timeout: no done after %0d cycles (required done)", tag, t);
        fin = 1;
      end else if (done0) begin
        if (exp_term) exp_t = (last_hs < 0) ? 3 : last_hs + 3;
        else          exp_t = (n == 0) ? 1 : last_hs + 1;
        checks++;
        if (t != exp_t) begin
          failures++;
          $display("FAIL %s done_time: got cycle %0d required %0d", tag, t, exp_t);
        end
        checks++;
        if (sent0 !== 12'(exp_c.size()) || idx != exp_c.size()) begin
          failures++;
          $display("FAIL %s sent_count: got %0d (handshakes %0d) required %0d",
                   tag, sent0, idx, exp_c.size());
        end
        checks++;
        if (busy0 !== 1'b1 || valid0 !== 1'b0) begin
          failures++;
          $display("FAIL %s fin_flags: busy=%b valid=%b required busy=1 valid=0",
                   tag, busy0, valid0);
        end
        fin = 1;
      end else if (valid0) begin
        if (!was_valid) begin
          exp_t = (idx == 0) ? 3 : last_hs + 3;
          checks++;
          if (idx >= exp_c.size()) begin
            failures++;
            $display("FAIL %s extra_char: got %h, none expected", tag, out0);
          end else if (out0 !== exp_c[idx] || t != exp_t || sent0 !== 12'(idx)) begin
            failures++;
            $display("FAIL %s char%0d: got %h at cycle %0d sent %0d required %h at %0d sent %0d",
                     tag, idx, out0, t, sent0, exp_c[idx], exp_t, idx);
          end
          held  = out0;
          stall = (mode == 1) ? 4 : (mode == 2) ? int'($urandom_range(0, 3)) : 0;
        end else begin
          checks++;
          if (out0 !== held || busy0 !== 1'b1) begin
            failures++;
            $display("FAIL %s stall_stable: got %h busy=%b required %h busy=1",
                     tag, out0, busy0, held);
          end
        end
        if (stall == 0) begin
          ready0 = 1'b1;
          checks++;
          if (idx < exp_a.size() && addr0 !== exp_a[idx]) begin
            failures++;
            $display("FAIL %s mem_addr%0d: got %h required %h", tag, idx, addr0, exp_a[idx]);
          end
          idx++;
          last_hs   = t;
          was_valid = 0;
        end else begin
          ready0    = 1'b0;
          stall--;
          was_valid = 1;
        end
      end else begin
        was_valid = 0;
        ready0 = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      end
    end
    @(negedge clk);
    checks++;
    if (done0 !== 1'b0 || busy0 !== 1'b0 || valid0 !== 1'b0) begin
      failures++;
      $display("FAIL %s after_done: done=%b busy=%b valid=%b required all 0",
               tag, done0, busy0, valid0);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({addr0, out0, valid0, busy0, done0, sent0} !== '0 ||
        {addr1, out1, valid1, busy1, done1, sent1} !== '0) begin
      failures++;
      $display("FAIL reset_state: dut0 addr=%h out=%h v=%b b=%b d=%b s=%0d dut1 addr=%h required all 0",
               addr0, out0, valid0, busy0, done0, sent0, addr1);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic load_basic;
    put(1, 6'd5); put(2, 6'd9); put(3, 6'd12); put(4, 6'h3F);
  endtask

  task automatic test_basic;
    load_basic();
    run_play(3, 0, "basic");
  endtask

  task automatic test_stall;
    load_basic();
    run_play(3, 1, "stall");
  endtask

  task automatic test_end_code;
    put(1, 6'd7); put(2, 6'h3F); put(3, 6'd8); put(4, 6'd9);
    run_play(4, 0, "end_code");
  endtask

  task automatic test_zero_count;
    run_play(0, 0, "zero_count");
  endtask

  task automatic test_back_to_back;
    load_basic();
    run_play(3, 0, "b2b_a");
    run_play(2, 0, "b2b_b");
  endtask

  task automatic test_restart_reset;
    load_basic();
    ready0 = 1'b1;
    start0 = 1'b1; cnt0 = 12'd3;
    @(negedge clk);                    // dut0 in ADDR: second start is ignored
    cnt0 = 12'd1;
    @(negedge clk);
    start0 = 1'b0;
    @(negedge clk);
    checks++;
    if (valid0 !== 1'b1 || out0 !== 6'd5) begin
      failures++;
      $display("FAIL restart_first: valid=%b out=%h required 1 05", valid0, out0);
    end
    @(negedge clk);
    checks++;
    if (done0 !== 1'b0 || valid0 !== 1'b0) begin
      failures++;
      $display("FAIL restart_ignored: done=%b valid=%b required 0 0", done0, valid0);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (valid0 !== 1'b1 || out0 !== 6'd9 || addr0 !== 12'd2 || sent0 !== 12'd1) begin
      failures++;
      $display("FAIL restart_second: valid=%b out=%h addr=%h sent=%0d required 1 09 002 1",
               valid0, out0, addr0, sent0);
    end
    ready0 = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (valid0 !== 1'b0 || busy0 !== 1'b0 || done0 !== 1'b0 || sent0 !== 12'd0 || addr0 !== 12'd0) begin
      failures++;
      $display("FAIL async_reset: valid=%b busy=%b done=%b sent=%0d addr=%h required all 0",
               valid0, busy0, done0, sent0, addr0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_play(3, 0, "replay");
  endtask

  task automatic test_wrap;
    int t, idx;
    bit fin;
    put(12'hFFF, 6'd21); put(0, 6'd34);
    build_exp(12'hFFF, 2);
    idx = 0; t = 0; fin = 0;
    ready1 = 1'b1;
    start1 = 1'b1; cnt1 = 12'd2;
    while (!fin) begin
      @(negedge clk);
      t++;
      start1 = 1'b0;
      if (t > 50) begin
        checks++; failures++;
        $display("FAIL wrap timeout: no done after %0d cycles", t);
        fin = 1;
      end else if (done1) begin
        checks++;
        if (idx != 2 || sent1 !== 12'd2) begin
          failures++;
          $display("FAIL wrap_count: handshakes %0d sent %0d required 2", idx, sent1);
        end
        fin = 1;
      end else if (valid1) begin
        checks++;
        if (idx >= 2 || out1 !== exp_c[idx] || addr1 !== exp_a[idx]) begin
          failures++;
          $display("FAIL wrap_char%0d: got %h @%h required %h @%h", idx, out1, addr1,
                   (idx < 2) ? exp_c[idx] : 6'd0, (idx < 2) ? exp_a[idx] : 12'd0);
        end
        idx++;
      end
    end
    @(negedge clk);
  endtask

  task automatic test_random;
    int n;
    for (int it = 0; it < 8; it++) begin
      n = int'($urandom_range(0, 10));
      for (int w = 1; w <= 12; w++) begin
        if ($urandom_range(0, 9) == 0) put(w, 6'h3F);
        else                           put(w, 6'($urandom_range(0, 62)));
      end
      run_play(n, 2, "random");
    end
  endtask

  initial begin
    rst_n = 1'b0;
    start0 = 1'b0; start1 = 1'b0;
    cnt0 = '0; cnt1 = '0;
    ready0 = 1'b0; ready1 = 1'b0;
    for (int i = 0; i < 4096; i++) mem[i] = '0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_stall();
    test_end_code();
    test_zero_count();
    test_back_to_back();
    test_restart_reset();
    test_wrap();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
